mmio_bridge: RTL and testbench
==============================

Name: mmio_bridge

Overview:
- Address decoder and access controller between the pipeline MEM stage and the two memory-bus targets: data memory and the polynomial accelerator device.
- Routes loads/stores by address and hosts a local status register.
- Tracks the accelerator's fixed compute latency after a start write.
- Stalls the pipeline on device-window accesses until the accelerator result is valid.

Parameters:
- DMEM_BYTES, 1024, size of the data-memory window starting at 0x00000000.
- DEV_LATENCY, 5, cycles from the accepted start-write edge until the device answer is final.
- CNT_W, 3, width of the busy counter; must hold DEV_LATENCY.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- cpu_mem_read  in  1  MEM-stage load
- cpu_mem_write  in  1  MEM-stage store
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data (combinational)
- cpu_stall  out  1  hold MEM stage and upstream this cycle
- dmem_read  out  1  data-memory read enable
- dmem_write  out  1  data-memory write enable
- dmem_addr  out  32  data-memory address
- dmem_wdata  out  32  data-memory write data
- dmem_rdata  in  32  data-memory read data
- dev_read  out  1  device read enable
- dev_write  out  1  device write enable
- dev_addr  out  32  device address
- dev_wdata  out  32  device write data
- dev_rdata  in  32  device read data
- busy  out  1  accelerator computing

Behaviour:
- Address map:
  - [0, DMEM_BYTES) → DMEM.
  - 0x40000000 op, 0x40000004 ans, 0x40000008 start → device window.
  - 0x4000000C → STATUS (local, read-only): bit0 busy, bit1 err_sticky, others 0.
  - Anything else → unmapped.
- Forwarding:
  - dmem_addr/dev_addr and dmem_wdata/dev_wdata are copies of cpu_addr/cpu_wdata.
  - Enables are gated by decode and by stall.
- cpu_rdata:
  - DMEM hit → dmem_rdata.
  - Device hit → dev_rdata.
  - STATUS → status word.
  - Unmapped or no read → 0.
- Unmapped access (read or write):
  - No target enabled; read returns 0.
  - err_sticky set on the clock edge.
  - Writes to STATUS are also unmapped errors.
- FSM states:
  - IDLE: busy=0, cnt=0.
  - BUSY: busy=1, cnt counts down.
- IDLE→BUSY: on a clock edge with an accepted store to 0x40000008 with cpu_wdata≠0. cnt loads DEV_LATENCY.
- A zero store to start is forwarded but does not start BUSY.
- In BUSY:
  - cnt decrements each edge.
  - When cnt==1 at an edge, go to IDLE (cnt→0).
  - Busy therefore lasts exactly DEV_LATENCY cycles after the start edge.
- Stall rule (combinational): cpu_stall=1 iff busy && (cpu_mem_read||cpu_mem_write) && address in device window.
  - While stalled, dev_read and dev_write are 0.
  - The pipeline holds its inputs stable, so the access completes the first cycle busy=0.
- Not stalled while busy: STATUS reads (for polling) and DMEM accesses.
- cpu_mem_read and cpu_mem_write both high: treated as a write for enables; cpu_rdata still muxed.
- Reset (any time, including mid-BUSY): state IDLE, cnt 0, err_sticky 0, busy 0, cpu_stall 0. All enables follow inputs combinationally.

Optional Feature:
- Macro: MMIO_ERR_COUNT_EN.
- When defined:
  - An 8-bit saturating counter increments on each unmapped-access edge (saturates at 0xFF).
  - Readable at 0x40000010 (zero-extended); reset to 0.
  - Writes to 0x40000010 clear it, and are not counted as errors.
- When undefined: 0x40000010 is unmapped like any other address.

Decomposition:
- Shared package mmio_pkg:
  - Address constants: DEV_OP_ADDR, DEV_ANS_ADDR, DEV_START_ADDR, STATUS_ADDR, ERRCNT_ADDR, DEV_BASE/DEV_LAST.
  - State typedef {IDLE, BUSY}.
  - Status bit indices.
- One sub-module: mmio_busy_timer.
  - Holds the FSM and counter.
  - Inputs: start_fire, clk, reset. Output: busy.
- Decode, mux and the error logic stay in mmio_bridge.

Test Plan:
- Store 0x12345678 to 0x00000010, then load it → dmem_write for 1 cycle; load returns 0x12345678; dev_* enables stay 0; no stall.
- Store 3 to 0x40000000, store 1 to 0x40000008, load 0x40000004 immediately → cpu_stall high for 5 cycles; dev_read then asserts; cpu_rdata = 121.
- During BUSY, poll 0x4000000C each cycle → reads 0x1 with no stall, then 0x0 exactly 5 cycles after the start edge.
- Store 0 to 0x40000008 → forwarded to device; busy stays 0; a following ans read is not stalled.
- Load 0x50000000 → cpu_rdata=0, no enables; next STATUS read shows bit1=1. With MMIO_ERR_COUNT_EN, 0x40000010 reads 1; after 300 errors it reads 0xFF.
- Assert reset 2 cycles into BUSY → busy and cpu_stall drop immediately; STATUS reads 0 after reset release.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared address map, FSM state type and status-bit layout for the MMIO bridge.
package mmio_pkg;

    localparam logic [31:0] DEV_OP_ADDR    = 32'h4000_0000;
    localparam logic [31:0] DEV_ANS_ADDR   = 32'h4000_0004;
    localparam logic [31:0] DEV_START_ADDR = 32'h4000_0008;
    localparam logic [31:0] STATUS_ADDR    = 32'h4000_000C;
    localparam logic [31:0] ERRCNT_ADDR    = 32'h4000_0010;
    localparam logic [31:0] DEV_BASE       = DEV_OP_ADDR;
    localparam logic [31:0] DEV_LAST       = DEV_START_ADDR;

    localparam int unsigned STATUS_BUSY_BIT = 0;
    localparam int unsigned STATUS_ERR_BIT  = 1;

    typedef enum logic {IDLE, BUSY} state_t;

    // Device registers sit on word boundaries only; anything in between is unmapped.
    function automatic logic in_dev_window(input logic [31:0] addr);
        return (addr >= DEV_BASE) && (addr <= DEV_LAST) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/mmio_busy_timer.sv
// Tracks the accelerator's fixed compute latency after an accepted start write.
module mmio_busy_timer #(
    parameter int unsigned DEV_LATENCY = 5,
    parameter int unsigned CNT_W       = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic start_fire,
    output logic busy
);
    import mmio_pkg::*;

    state_t             state;
    logic [CNT_W-1:0]   cnt;

    // Busy spans exactly DEV_LATENCY cycles: load on the start edge, leave when cnt reaches 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_fire) begin
                        state <= BUSY;
                        cnt   <= CNT_W'(DEV_LATENCY);
                    end
                end
                BUSY: begin
                    if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy = (state == BUSY);

endmodule

// File: rtl/mmio_bridge.sv
// MEM-stage address decoder routing to data memory, the accelerator and a local status register.
// Optional MMIO_ERR_COUNT_EN adds a saturating unmapped-access counter at 0x40000010.
module mmio_bridge #(
    parameter int unsigned DMEM_BYTES  = 1024,
    parameter int unsigned DEV_LATENCY = 5,
    parameter int unsigned CNT_W       = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_mem_read,
    input  logic        cpu_mem_write,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    output logic        dev_read,
    output logic        dev_write,
    output logic [31:0] dev_addr,
    output logic [31:0] dev_wdata,
    input  logic [31:0] dev_rdata,
    output logic        busy
);
    import mmio_pkg::*;

    logic        access;
    logic        rd_only;
    logic        hit_dmem;
    logic        hit_dev;
    logic        hit_status;
    logic        hit_errcnt;
    logic        mapped;
    logic        unmapped_fire;
    logic        start_fire;
    logic        err_sticky;
    logic [31:0] status_word;

    assign access     = cpu_mem_read | cpu_mem_write;
    assign rd_only    = cpu_mem_read & ~cpu_mem_write;
    assign hit_dmem   = (cpu_addr < 32'(DMEM_BYTES));
    assign hit_dev    = in_dev_window(cpu_addr);
    assign hit_status = (cpu_addr == STATUS_ADDR);

`ifdef MMIO_ERR_COUNT_EN
    logic [7:0] err_cnt;
    assign hit_errcnt = (cpu_addr == ERRCNT_ADDR);
`else
    assign hit_errcnt = 1'b0;
`endif

    // STATUS is read-only, so a store to it counts as unmapped.
    assign mapped        = hit_dmem | hit_dev | (hit_status & ~cpu_mem_write) | hit_errcnt;
    assign unmapped_fire = access & ~mapped;

    assign cpu_stall  = busy & access & hit_dev;

    assign dmem_addr  = cpu_addr;
    assign dmem_wdata = cpu_wdata;
    assign dev_addr   = cpu_addr;
    assign dev_wdata  = cpu_wdata;

    assign dmem_write = cpu_mem_write & hit_dmem;
    assign dmem_read  = rd_only & hit_dmem;
    assign dev_write  = cpu_mem_write & hit_dev & ~cpu_stall;
    assign dev_read   = rd_only & hit_dev & ~cpu_stall;

    assign start_fire = dev_write & (cpu_addr == DEV_START_ADDR) & (cpu_wdata != 32'd0);

    mmio_busy_timer #(
        .DEV_LATENCY (DEV_LATENCY),
        .CNT_W       (CNT_W)
    ) u_busy_timer (
        .clk        (clk),
        .reset      (reset),
        .start_fire (start_fire),
        .busy       (busy)
    );

    always_comb begin
        status_word                  = '0;
        status_word[STATUS_BUSY_BIT] = busy;
        status_word[STATUS_ERR_BIT]  = err_sticky;
    end

    // Read mux: a load sees its target's data; unmapped or no load returns zero.
    always_comb begin
        cpu_rdata = '0;
        if (cpu_mem_read) begin
            if (hit_dmem)        cpu_rdata = dmem_rdata;
            else if (hit_dev)    cpu_rdata = dev_rdata;
            else if (hit_status) cpu_rdata = status_word;
`ifdef MMIO_ERR_COUNT_EN
            else if (hit_errcnt) cpu_rdata = 32'(err_cnt);
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_sticky <= 1'b0;
        end else if (unmapped_fire) begin
            err_sticky <= 1'b1;
        end
    end

`ifdef MMIO_ERR_COUNT_EN
    // Stores to the counter clear it; unmapped accesses bump it up to 0xFF.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt <= '0;
        end else if (cpu_mem_write && hit_errcnt) begin
            err_cnt <= '0;
        end else if (unmapped_fire && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge: directed scenarios plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_mmio_bridge;

    localparam logic [31:0] A_OP     = 32'h4000_0000;
    localparam logic [31:0] A_ANS    = 32'h4000_0004;
    localparam logic [31:0] A_START  = 32'h4000_0008;
    localparam logic [31:0] A_STATUS = 32'h4000_000C;
    localparam logic [31:0] A_ERRCNT = 32'h4000_0010;
    localparam int          LAT      = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_mem_read, cpu_mem_write;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall, busy;
    logic        dmem_read, dmem_write, dev_read, dev_write;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [31:0] dev_addr, dev_wdata, dev_rdata;

    int n_pass  = 0;
    int n_total = 0;

    mmio_bridge dut (
        .clk(clk), .reset(reset),
        .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dev_read(dev_read), .dev_write(dev_write), .dev_addr(dev_addr),
        .dev_wdata(dev_wdata), .dev_rdata(dev_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // ---------------- bus-side memory and accelerator ----------------
    logic [31:0] bus_mem [256];
    logic [31:0] dv_op, dv_ans;

    function automatic logic [31:0] poly(input logic [31:0] x);
        return x*x*x*x + x*x*x + x*x + x + 32'd1;
    endfunction

    function automatic logic [31:0] dev_value(input logic [31:0] a);
        if (a == A_ANS)   return dv_ans;
        if (a == A_OP)    return dv_op;
        if (a == A_START) return 32'h5A5A_0008;
        return 32'hBAD0_BAD0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) bus_mem[i] <= 32'h0;
            dv_op  <= 32'h0;
            dv_ans <= 32'h0;
        end else begin
            if (dmem_write) bus_mem[dmem_addr[9:2]] <= dmem_wdata;
            if (dev_write && dev_addr == A_OP) dv_op <= dev_wdata;
            if (dev_write && dev_addr == A_START && dev_wdata != 32'h0) dv_ans <= poly(dv_op);
        end
    end

    assign dmem_rdata = bus_mem[cpu_addr[9:2]];
    assign dev_rdata  = dev_value(cpu_addr);

    // ---------------- behavioural model ----------------
    logic [31:0] ref_mem [256];
    int          m_left;
    bit          m_err;
    int          m_cnt;

    function automatic bit is_dev(input logic [31:0] a);
        return (a == A_OP) || (a == A_ANS) || (a == A_START);
    endfunction

    function automatic bit is_mapped(input logic [31:0] a, input logic w);
        bit m;
        m = (a < 32'd1024) || is_dev(a) || (a == A_STATUS && !w);
`ifdef MMIO_ERR_COUNT_EN
        m = m || (a == A_ERRCNT);
`endif
        return m;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left <= 0;
            m_err  <= 1'b0;
            m_cnt  <= 0;
            for (int i = 0; i < 256; i++) ref_mem[i] <= 32'h0;
        end else begin
            if (m_left > 0) m_left <= m_left - 1;
            else if (cpu_mem_write && cpu_addr == A_START && cpu_wdata != 32'h0) m_left <= LAT;
            if ((cpu_mem_read || cpu_mem_write) && !is_mapped(cpu_addr, cpu_mem_write)) begin
                m_err <= 1'b1;
                if (m_cnt < 255) m_cnt <= m_cnt + 1;
            end
`ifdef MMIO_ERR_COUNT_EN
            if (cpu_mem_write && cpu_addr == A_ERRCNT) m_cnt <= 0;
`endif
            if (cpu_mem_write && cpu_addr < 32'd1024) ref_mem[cpu_addr[9:2]] <= cpu_wdata;
        end
    end

    function automatic logic [31:0] exp_rdata();
        logic [31:0] a;
        a = cpu_addr;
        if (!cpu_mem_read)     return 32'h0;
        if (a < 32'd1024)      return ref_mem[a[9:2]];
        if (is_dev(a))         return dev_value(a);
        if (a == A_STATUS)     return {30'h0, m_err, (m_left > 0)};
`ifdef MMIO_ERR_COUNT_EN
        if (a == A_ERRCNT)     return 32'(m_cnt);
`endif
        return 32'h0;
    endfunction

    // Per-cycle compare of every DUT output against the model.
    always @(negedge clk) begin
        bit mb, acc, dv, st, rdo;
        mb  = (m_left > 0);
        acc = cpu_mem_read || cpu_mem_write;
        dv  = is_dev(cpu_addr);
        st  = mb && acc && dv;
        rdo = cpu_mem_read && !cpu_mem_write;
        check("cyc_ctl",
              64'({dmem_read, dmem_write, dev_read, dev_write, cpu_stall, busy}),
              64'({rdo && cpu_addr < 32'd1024, cpu_mem_write && cpu_addr < 32'd1024,
                   rdo && dv && !st, cpu_mem_write && dv && !st, st, mb}));
        check("cyc_rdata", 64'(cpu_rdata), 64'(exp_rdata()));
        check("cyc_dmem_fwd", {dmem_addr, dmem_wdata}, {cpu_addr, cpu_wdata});
        check("cyc_dev_fwd", {dev_addr, dev_wdata}, {cpu_addr, cpu_wdata});
    end

    task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        cpu_mem_read  = r;
        cpu_mem_write = w;
        cpu_addr      = a;
        cpu_wdata     = d;
    endtask

    initial begin
        int stalls;
        reset = 1'b1;
        cpu_mem_read = 1'b0; cpu_mem_write = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;

        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_stall", 64'(cpu_stall), 64'd0);
        check("rst_rdata", 64'(cpu_rdata), 64'd0);
        @(posedge clk); #1 reset = 1'b0;

        // DMEM store then load
        drive(0, 1, 32'h10, 32'h1234_5678);
        @(negedge clk);
        check("d1_dmem_wr", 64'({dmem_write, dev_read, dev_write, cpu_stall}), 64'b1000);
        drive(1, 0, 32'h10, 32'h0);
        @(negedge clk);
        check("d1_load", 64'(cpu_rdata), 64'h1234_5678);
        check("d1_dmem_rd", 64'({dmem_read, dmem_write, dev_read}), 64'b100);

        // op=3, start, immediate answer read stalls for the whole latency
        drive(0, 1, A_OP, 32'd3);
        drive(0, 1, A_START, 32'd1);
        @(negedge clk);
        check("d2_start_wr", 64'({dev_write, busy}), 64'b10);
        drive(1, 0, A_ANS, 32'h0);
        stalls = 0;
        @(negedge clk);
        while (cpu_stall && stalls < 20) begin
            check("d2_no_dev_rd", 64'(dev_read), 64'd0);
            stalls++;
            @(negedge clk);
        end
        check("d2_stall_cycles", 64'(stalls), 64'd5);
        check("d2_dev_read", 64'(dev_read), 64'd1);
        check("d2_ans", 64'(cpu_rdata), 64'd121);

        // STATUS polling during busy
        drive(0, 1, A_START, 32'd1);
        for (int k = 0; k < 6; k++) begin
            drive(1, 0, A_STATUS, 32'h0);
            @(negedge clk);
            check("d3_poll", 64'({cpu_stall, cpu_rdata}), (k < 5) ? 64'd1 : 64'd0);
        end

        // zero start is forwarded but does not start the timer
        drive(0, 1, A_START, 32'd0);
        @(negedge clk);
        check("d4_zero_fwd", 64'(dev_write), 64'd1);
        drive(1, 0, A_ANS, 32'h0);
        @(negedge clk);
        check("d4_no_busy", 64'({cpu_stall, busy}), 64'd0);
        check("d4_ans_kept", 64'(cpu_rdata), 64'd121);

        // unmapped access
        drive(1, 0, 32'h5000_0000, 32'h0);
        @(negedge clk);
        check("d5_unmapped", 64'({dmem_read, dmem_write, dev_read, dev_write, cpu_rdata}), 64'd0);
        drive(1, 0, A_STATUS, 32'h0);
        @(negedge clk);
        check("d5_status_err", 64'(cpu_rdata), 64'd2);
`ifdef MMIO_ERR_COUNT_EN
        drive(1, 0, A_ERRCNT, 32'h0);
        @(negedge clk);
        check("d5_errcnt_1", 64'(cpu_rdata), 64'd1);
        repeat (300) drive(1, 0, 32'h5000_0000, 32'h0);
        drive(1, 0, A_ERRCNT, 32'h0);
        @(negedge clk);
        check("d5_errcnt_sat", 64'(cpu_rdata), 64'hFF);
        drive(0, 1, A_ERRCNT, 32'h0);
        drive(1, 0, A_ERRCNT, 32'h0);
        @(negedge clk);
        check("d5_errcnt_clr", 64'(cpu_rdata), 64'd0);
`else
        drive(1, 0, A_ERRCNT, 32'h0);
        @(negedge clk);
        check("d5_errcnt_unmapped", 64'(cpu_rdata), 64'd0);
`endif

        // reset mid-busy
        drive(0, 1, A_START, 32'd1);
        drive(0, 0, 32'h0, 32'h0);
        drive(1, 0, A_ANS, 32'h0);
        @(negedge clk);
        check("d6_pre_stall", 64'({cpu_stall, busy}), 64'b11);
        #2 reset = 1'b1;
        #1;
        check("d6_rst_drop", 64'({cpu_stall, busy}), 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        drive(1, 0, A_STATUS, 32'h0);
        @(negedge clk);
        check("d6_status_clr", 64'(cpu_rdata), 64'd0);

        // randomized traffic; hold inputs while stalled
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a, d;
            int kind, rw;
            @(posedge clk);
            #1;
            if (!cpu_stall) begin
                kind = $urandom_range(0, 9);
                d    = $urandom;
                case (kind)
                    0, 1, 2, 3: a = 32'($urandom_range(0, 255)) << 2;
                    4: a = A_OP;
                    5: a = A_ANS;
                    6: begin a = A_START; if ($urandom_range(0, 3) == 0) d = 32'h0; end
                    7: a = A_STATUS;
                    8: a = A_ERRCNT;
                    default: begin
                        case ($urandom_range(0, 3))
                            0: a = 32'h0000_0400;
                            1: a = 32'h5000_0000;
                            2: a = 32'h4000_0014;
                            default: a = $urandom | 32'h8000_0000;
                        endcase
                    end
                endcase
                rw = $urandom_range(0, 3);
                cpu_mem_read  = (rw == 1) || (rw == 3);
                cpu_mem_write = (rw == 2) || (rw == 3);
                cpu_addr      = a;
                cpu_wdata     = d;
            end
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
